// File: rtl/bus_register_core.sv
// Register file (R0-R15, PC, HI, LO, Z_HI, Z_LO, MDR) and shared-bus source selector
// for the single-bus datapath; the highest-indexed drive strobe owns the bus.
module bus_register_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [15:0]      Rin,
    input  logic [15:0]      Rout,
    input  logic             PCin,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             ZHIin,
    input  logic             ZLOin,
    input  logic [WIDTH-1:0] ZHI_d,
    input  logic [WIDTH-1:0] ZLO_d,
    input  logic             MDRin,
    input  logic             Read,
    input  logic [WIDTH-1:0] MDatain,
    input  logic [WIDTH-1:0] InPort_d,
    input  logic [WIDTH-1:0] Csign_d,
    input  logic             PCout,
    input  logic             HIout,
    input  logic             LOout,
    input  logic             Zhighout,
    input  logic             Zlowout,
    input  logic             MDRout,
    input  logic             InPortout,
    input  logic             Cout,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [4:0]       sel_code,
    output logic             sel_valid
);

    logic [WIDTH-1:0] r_gpr [16];
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_zhi;
    logic [WIDTH-1:0] r_zlo;
    logic [WIDTH-1:0] r_mdr;

    logic [31:0]      w_req;
    logic [WIDTH-1:0] w_mdr_d;

    assign w_req   = {8'b0, Cout, InPortout, MDRout, PCout, Zlowout, Zhighout,
                      LOout, HIout, Rout};
    assign w_mdr_d = Read ? MDatain : BusMuxOut;

    // Bus loads sample the pre-edge bus, so register-to-register copies work in one cycle.
    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < 16; i++) begin
                r_gpr[i] <= '0;
            end
            r_pc  <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_zhi <= '0;
            r_zlo <= '0;
            r_mdr <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (Rin[i]) begin
                    r_gpr[i] <= BusMuxOut;
                end
            end
            if (PCin)  r_pc  <= BusMuxOut;
            if (HIin)  r_hi  <= BusMuxOut;
            if (LOin)  r_lo  <= BusMuxOut;
            if (ZHIin) r_zhi <= ZHI_d;
            if (ZLOin) r_zlo <= ZLO_d;
            if (MDRin) r_mdr <= w_mdr_d;
        end
    end

    // Ascending scan: the last set bit seen wins, giving highest-index priority.
    always_comb begin
        sel_code  = 5'd31;
        sel_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (w_req[i]) begin
                sel_code  = 5'(i);
                sel_valid = 1'b1;
            end
        end
    end

    always_comb begin
        BusMuxOut = '0;
        if (sel_code < 5'd16) begin
            BusMuxOut = r_gpr[sel_code[3:0]];
        end else begin
            case (sel_code)
                5'd16:   BusMuxOut = r_hi;
                5'd17:   BusMuxOut = r_lo;
                5'd18:   BusMuxOut = r_zhi;
                5'd19:   BusMuxOut = r_zlo;
                5'd20:   BusMuxOut = r_pc;
                5'd21:   BusMuxOut = r_mdr;
                5'd22:   BusMuxOut = InPort_d;
                5'd23:   BusMuxOut = Csign_d;
                default: BusMuxOut = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_register_core.sv
// Self-checking bench for bus_register_core: directed sequences, a priority table
// and randomized traffic compared against a behavioural register-file model.
module tb_bus_register_core;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] Rin, Rout;
    logic        PCin, HIin, LOin, ZHIin, ZLOin, MDRin, Read;
    logic [31:0] ZHI_d, ZLO_d, MDatain, InPort_d, Csign_d;
    logic        PCout, HIout, LOout, Zhighout, Zlowout, MDRout, InPortout, Cout;
    logic [31:0] BusMuxOut;
    logic [4:0]  sel_code;
    logic        sel_valid;

    int checks = 0;
    int errors = 0;

    // Model state: src index order R0..R15, HI, LO, Z_HI, Z_LO, PC, MDR
    logic [31:0] m_reg [22];

    always #5 clk = ~clk;

    bus_register_core #(.WIDTH(32)) dut (
        .clk(clk), .clr(clr), .Rin(Rin), .Rout(Rout),
        .PCin(PCin), .HIin(HIin), .LOin(LOin), .ZHIin(ZHIin), .ZLOin(ZLOin),
        .ZHI_d(ZHI_d), .ZLO_d(ZLO_d), .MDRin(MDRin), .Read(Read), .MDatain(MDatain),
        .InPort_d(InPort_d), .Csign_d(Csign_d),
        .PCout(PCout), .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout),
        .Zlowout(Zlowout), .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout),
        .BusMuxOut(BusMuxOut), .sel_code(sel_code), .sel_valid(sel_valid)
    );

    typedef struct {
        logic [15:0] rout;
        logic [7:0]  misc;      // {C, InPort, MDR, PC, Zlo, Zhi, LO, HI}
        logic [4:0]  exp_code;
        logic        exp_valid;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [23:0] cur_req();
        return {Cout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout, Rout};
    endfunction

    function automatic logic [31:0] source_value(input int idx);
        if (idx < 22) return m_reg[idx];
        if (idx == 22) return InPort_d;
        if (idx == 23) return Csign_d;
        return 32'h0;
    endfunction

    function automatic int model_sel(input logic [23:0] req);
        int winner = 31;
        for (int i = 23; i >= 0; i--) begin
            if (req[i]) begin
                winner = i;
                break;
            end
        end
        return winner;
    endfunction

    function automatic logic [31:0] model_bus(input logic [23:0] req);
        return source_value(model_sel(req));
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        int code = model_sel(cur_req());
        check32({name, ".bus"}, BusMuxOut, model_bus(cur_req()));
        check32({name, ".code"}, {27'b0, sel_code}, code);
        check32({name, ".valid"}, {31'b0, sel_valid}, (code != 31) ? 1 : 0);
    endtask

    task automatic idle();
        clr = 1'b1; Rin = '0; Rout = '0;
        PCin = 0; HIin = 0; LOin = 0; ZHIin = 0; ZLOin = 0; MDRin = 0; Read = 0;
        PCout = 0; HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0;
        MDRout = 0; InPortout = 0; Cout = 0;
    endtask

    // One rising edge; the model updates from the inputs and bus seen before it.
    task automatic step();
        logic [31:0] bus_pre;
        bus_pre = model_bus(cur_req());
        @(posedge clk);
        if (!clr) begin
            for (int i = 0; i < 22; i++) m_reg[i] = 32'h0;
        end else begin
            for (int i = 0; i < 16; i++) if (Rin[i]) m_reg[i] = bus_pre;
            if (HIin)  m_reg[16] = bus_pre;
            if (LOin)  m_reg[17] = bus_pre;
            if (ZHIin) m_reg[18] = ZHI_d;
            if (ZLOin) m_reg[19] = ZLO_d;
            if (PCin)  m_reg[20] = bus_pre;
            if (MDRin) m_reg[21] = Read ? MDatain : bus_pre;
        end
        #1;
    endtask

    task automatic set_misc(input logic [7:0] m);
        {Cout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout} = m;
    endtask

    // Drive a constant over the bus into the selected registers.
    task automatic load_const(input logic [31:0] v, input logic [15:0] rin,
                              input logic pc, input logic hi, input logic lo);
        idle();
        Cout = 1; Csign_d = v; Rin = rin; PCin = pc; HIin = hi; LOin = lo;
        step();
        idle();
    endtask

    initial begin
        for (int i = 0; i < 22; i++) m_reg[i] = 32'h0;
        ZHI_d = 0; ZLO_d = 0; MDatain = 0; InPort_d = 0; Csign_d = 0;
        idle();
        clr = 0;
        step();
        idle();
        #1;
        check32("rst.bus", BusMuxOut, 32'h0);
        check32("rst.code", {27'b0, sel_code}, 32'd31);
        check32("rst.valid", {31'b0, sel_valid}, 32'd0);

        load_const(32'hDEADBEEF, 16'h0008, 0, 0, 0);
        Rout[3] = 1; #1;
        check32("r3.loaded", BusMuxOut, 32'hDEADBEEF);
        clr = 0; step(); idle();
        Rout[3] = 1; #1;
        check32("r3.cleared", BusMuxOut, 32'h0);
        check32("r3.code", {27'b0, sel_code}, 32'd3);

        idle(); MDatain = 32'h22; Read = 1; MDRin = 1; step();
        idle(); MDRout = 1; #1;
        check32("mdr.mem", BusMuxOut, 32'h22);
        check32("mdr.code", {27'b0, sel_code}, 32'd21);
        MDatain = 32'h55; step(); #1;
        check32("mdr.hold", BusMuxOut, 32'h22);

        idle(); MDRout = 1; Read = 0; Rin[2] = 1; step();
        idle(); Rout[2] = 1; #1;
        check32("xfer.r2", BusMuxOut, 32'h22);
        check32("xfer.code", {27'b0, sel_code}, 32'd2);
        idle(); MDRout = 1; MDRin = 1; Read = 0; step(); #1;
        check32("mdr.loop", BusMuxOut, 32'h22);

        load_const(32'h00000100, 16'h0, 1, 0, 0);
        Rout[2] = 1; Rout[3] = 1; PCout = 1; #1;
        check32("prio.pc", BusMuxOut, 32'h100);
        check32("prio.pccode", {27'b0, sel_code}, 32'd20);
        PCout = 0; #1;
        check32("prio.r3code", {27'b0, sel_code}, 32'd3);
        idle(); Cout = 1; Csign_d = 32'hFFFFFFF0; #1;
        check32("prio.c", BusMuxOut, 32'hFFFFFFF0);
        check32("prio.ccode", {27'b0, sel_code}, 32'd23);

        idle(); ZLO_d = 32'h12345678; ZHI_d = 32'h9; ZLOin = 1; ZHIin = 1; step();
        idle(); Zlowout = 1; #1;
        check32("z.lo", BusMuxOut, 32'h12345678);
        check32("z.locode", {27'b0, sel_code}, 32'd19);
        idle(); Zhighout = 1; #1;
        check32("z.hi", BusMuxOut, 32'h9);
        check32("z.hicode", {27'b0, sel_code}, 32'd18);

        idle(); Cout = 1; Csign_d = 32'hAAAA5555; Rin[5] = 1; clr = 0; step();
        idle(); Rout[5] = 1; #1;
        check32("rstpri.r5", BusMuxOut, 32'h0);
        idle(); Cout = 1; Csign_d = 32'hAAAA5555; Rin[5] = 1; step();
        idle(); Rout[5] = 1; #1;
        check32("rstpri.r5load", BusMuxOut, 32'hAAAA5555);

        // Distinct value in every source for the priority table.
        for (int i = 0; i < 16; i++) load_const(32'h1000_0000 + i, 16'(1 << i), 0, 0, 0);
        load_const(32'hA0A0_0010, 16'h0, 0, 1, 0);
        load_const(32'hA0A0_0011, 16'h0, 0, 0, 1);
        load_const(32'hA0A0_0014, 16'h0, 1, 0, 0);
        idle(); ZHI_d = 32'hA0A0_0012; ZLO_d = 32'hA0A0_0013; ZHIin = 1; ZLOin = 1; step();
        idle(); MDatain = 32'hA0A0_0015; Read = 1; MDRin = 1; step();
        idle(); InPort_d = 32'hA0A0_0016; Csign_d = 32'hA0A0_0017;

        vecs[0]  = '{16'h0000, 8'h00, 5'd31, 1'b0};
        vecs[1]  = '{16'h0001, 8'h00, 5'd0,  1'b1};
        vecs[2]  = '{16'h8000, 8'h00, 5'd15, 1'b1};
        vecs[3]  = '{16'hFFFF, 8'h01, 5'd16, 1'b1};
        vecs[4]  = '{16'h0000, 8'h02, 5'd17, 1'b1};
        vecs[5]  = '{16'h0000, 8'h04, 5'd18, 1'b1};
        vecs[6]  = '{16'h0000, 8'h08, 5'd19, 1'b1};
        vecs[7]  = '{16'h000C, 8'h10, 5'd20, 1'b1};
        vecs[8]  = '{16'h0000, 8'h20, 5'd21, 1'b1};
        vecs[9]  = '{16'h0000, 8'h40, 5'd22, 1'b1};
        vecs[10] = '{16'hFFFF, 8'hFF, 5'd23, 1'b1};
        vecs[11] = '{16'h0410, 8'h00, 5'd10, 1'b1};
        for (int v = 0; v < 12; v++) begin
            idle();
            Rout = vecs[v].rout;
            set_misc(vecs[v].misc);
            #1;
            check32($sformatf("tbl%0d.code", v), {27'b0, sel_code}, {27'b0, vecs[v].exp_code});
            check32($sformatf("tbl%0d.valid", v), {31'b0, sel_valid}, {31'b0, vecs[v].exp_valid});
            check32($sformatf("tbl%0d.bus", v), BusMuxOut,
                    vecs[v].exp_valid ? source_value(int'(vecs[v].exp_code)) : 32'h0);
        end

        for (int n = 0; n < 400; n++) begin
            idle();
            clr = ($urandom_range(0, 19) != 0);
            Rin = 16'($urandom) & 16'($urandom);
            PCin = ($urandom_range(0, 3) == 0); HIin = ($urandom_range(0, 3) == 0);
            LOin = ($urandom_range(0, 3) == 0); ZHIin = ($urandom_range(0, 3) == 0);
            ZLOin = ($urandom_range(0, 3) == 0); MDRin = ($urandom_range(0, 3) == 0);
            Read = $urandom_range(0, 1);
            ZHI_d = $urandom; ZLO_d = $urandom; MDatain = $urandom;
            InPort_d = $urandom; Csign_d = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                Rout = 16'(1 << $urandom_range(0, 15)) | (16'($urandom) & 16'($urandom) & 16'($urandom));
                set_misc(8'($urandom) & 8'($urandom) & 8'($urandom));
            end
            #1;
            check_model($sformatf("rnd%0d", n));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_register_core.md
Name: bus_register_core

Overview:
- 32-bit register file and bus-source selector for the single-bus CPU datapath.
- Holds R0–R15, PC, HI, LO, Z_HI, Z_LO and the MDR.
- Converts the one-hot "out" strobes into a 5-bit select code with a priority encoder, and drives the shared bus from the selected source.
- Sits between the control unit (strobes), memory (MDatain), the ALU (Z inputs) and the rest of the datapath (BusMuxOut).

Parameters:
- WIDTH, 32, data width of every register and of the bus.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  synchronous active-low reset.
- Rin  in  16  per-GPR load enables, bit i = Ri.
- Rout  in  16  per-GPR bus-drive strobes, bit i = Ri.
- PCin, HIin, LOin  in  1 each  load enables; data from BusMuxOut.
- ZHIin, ZLOin  in  1 each  load enables for Z_HI/Z_LO; data from ZHI_d/ZLO_d.
- ZHI_d, ZLO_d  in  WIDTH each  ALU result high/low words.
- MDRin  in  1  MDR load enable.
- Read  in  1  MDR source select: 1 = MDatain, 0 = BusMuxOut.
- MDatain  in  WIDTH  memory read data.
- InPort_d  in  WIDTH  input-port value, driven to the bus by InPortout.
- Csign_d  in  WIDTH  sign-extended constant, driven to the bus by Cout.
- PCout, HIout, LOout, Zhighout, Zlowout, MDRout, InPortout, Cout  in  1 each  bus-drive strobes.
- BusMuxOut  out  WIDTH  shared bus value.
- sel_code  out  5  encoder output.
- sel_valid  out  1  1 when any drive strobe is set.

Behaviour:
Clock and reset:
- One clock (clk).
- clr is synchronous and active-low: on the rising edge with clr=0, every register (R0–R15, PC, HI, LO, Z_HI, Z_LO, MDR) becomes 0.
- Reset has priority over all load enables.
- Outputs are combinational from state and strobes. After reset with all strobes 0: BusMuxOut=0, sel_code=31, sel_valid=0.

Register loads:
- Generic 32-bit register: on the rising edge, if clr=1 and its enable=1, q<=d; otherwise it holds.
- Loads are visible on the bus the following cycle; latency is 1 clock.
- Multiple enables may be set in the same cycle; all enabled registers load.

MDR:
- On the rising edge, if MDRin=1: MDR <= (Read ? MDatain : BusMuxOut); otherwise it holds.

Select encoder:
- The 32-bit request vector is {8'b0, Cout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout, Rout[15:0]}.
- Resulting indices: R0–R15 = 0–15, HI=16, LO=17, Z_HI=18, Z_LO=19, PC=20, MDR=21, InPort=22, C=23.
- Priority encoder: sel_code = index of the highest set bit, so simultaneous strobes resolve to the highest index.
- If no bit is set: sel_code=31 and sel_valid=0.

Bus mux:
- BusMuxOut = the source at sel_code.
- Codes 24–31 drive 0.

Loop-through:
- BusMuxOut feeding a register's d in the same cycle is legal and loads the pre-edge bus value. Example: R1out=1 with R2in=1 copies R1 to R2.

Test Plan:
- Reset: load R3=0xDEADBEEF, then clr=0 for one edge → R3out shows 0; all strobes low → BusMuxOut=0, sel_code=31, sel_valid=0.
- MDR from memory: MDatain=0x00000022, Read=1, MDRin=1, one edge → MDRout=1 gives BusMuxOut=0x22, sel_code=21. Then MDRin=0 and MDatain changes → value holds.
- Transfer: MDR=0x22 with MDRout=1, Read=0, R2in=1, one edge → R2out gives 0x22, sel_code=2. Then MDRout=1, MDRin=1, Read=0 → MDR reloads from the bus unchanged.
- Priority: R2out=1, R3out=1, PCout=1 → sel_code=20, BusMuxOut=PC. Drop PCout → sel_code=3. Cout alone with Csign_d=0xFFFFFFF0 → BusMuxOut=0xFFFFFFF0, sel_code=23.
- Z path: ZLO_d=0x12345678, ZHI_d=0x9, ZLOin=ZHIin=1, one edge → Zlowout gives 0x12345678 (code 19); Zhighout gives 0x9 (code 18).
- Reset versus enable: clr=0 with R5in=1 and bus=0xAAAA5555 → R5=0. Then clr=1 on the next edge → R5=0xAAAA5555.
